// File: rtl/stability_pkg.sv
// rtl/stability_pkg.sv - shared types and defaults for the operand stability monitor
package stability_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_WIN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WATCH  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/stab_cmp.sv
// rtl/stab_cmp.sv - reference capture and change accumulation datapath
module stab_cmp
    import stability_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             clear,
    input  logic             cmp_en,
    input  logic [W-1:0]     data,
    input  logic [WIN_W-1:0] cnt,
    output logic             err,
    output logic [W-1:0]     err_mask,
    output logic [WIN_W-1:0] err_cyc
);

    logic [W-1:0] ref_q;
    logic [W-1:0] diff;

    assign diff = data ^ ref_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q    <= '0;
            err      <= 1'b0;
            err_mask <= '0;
            err_cyc  <= '0;
        end else if (capture) begin
            ref_q    <= data;
            err      <= 1'b0;
            err_mask <= '0;
            err_cyc  <= '0;
        end else if (clear) begin
            err      <= 1'b0;
            err_mask <= '0;
            err_cyc  <= '0;
        end else if (cmp_en) begin
            err_mask <= err_mask | diff;
            // Only the first offending cycle is recorded.
            if ((diff != '0) && !err) begin
                err     <= 1'b1;
                err_cyc <= cnt;
            end
        end
    end

endmodule

// File: rtl/stability_monitor_ctrl.sv
// rtl/stability_monitor_ctrl.sv - window sequencer for operand stability checking
module stability_monitor_ctrl
    import stability_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win,
    input  logic [W-1:0]     data,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     err_mask,
    output logic [WIN_W-1:0] err_cyc
);

    state_t           state, state_nxt;
    logic [WIN_W-1:0] cnt;
    logic [WIN_W-1:0] win_l;
    logic             capture;
    logic             clear;
    logic             cmp_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            win_l <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cnt   <= '0;
                win_l <= win;
            end else if (state == ST_WATCH) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        clear     = 1'b0;
        cmp_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                // START takes priority over ACK; the capture clears results anyway.
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = (win != '0) ? ST_WATCH : ST_REPORT;
                end else if (ack) begin
                    clear = 1'b1;
                end
            end
            ST_WATCH: begin
                busy   = 1'b1;
                cmp_en = 1'b1;
                // Exit compare fires before cnt could wrap at the maximum window.
                if (cnt == (win_l - 1'b1)) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    stab_cmp #(
        .W     (W),
        .WIN_W (WIN_W)
    ) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (capture),
        .clear    (clear),
        .cmp_en   (cmp_en),
        .data     (data),
        .cnt      (cnt),
        .err      (err),
        .err_mask (err_mask),
        .err_cyc  (err_cyc)
    );

endmodule

// File: tb/tb_stability_monitor_ctrl.sv
// tb/tb_stability_monitor_ctrl.sv - self-checking bench for stability_monitor_ctrl
module tb_stability_monitor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] win;
    logic [7:0] data;
    logic       ack;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] err_mask;
    logic [3:0] err_cyc;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] dseq [16];

    typedef struct {
        int         w;
        logic [7:0] ref_v;
        int         ia;
        logic [7:0] va;
        int         ib;
        logic [7:0] vb;
        bit         hold;
        bit         ackw;
        bit         ackst;
        bit         e_err;
        logic [7:0] e_mask;
        int         e_cyc;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    stability_monitor_ctrl #(.W(8), .WIN_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .win      (win),
        .data     (data),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_mask (err_mask),
        .err_cyc  (err_cyc)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_res(input string name, input bit e_err, input logic [7:0] e_mask, input int e_cyc);
        chk({name, " err"}, int'(err), int'(e_err));
        chk({name, " err_mask"}, int'(err_mask), int'(e_mask));
        chk({name, " err_cyc"}, int'(err_cyc), e_cyc);
    endtask

    // dseq[k] is the DATA value seen by the compare with cnt == k.
    task automatic run_window(input string tag, input int w, input logic [7:0] ref_v,
                              input bit hold, input bit ackw, input bit ackst,
                              input bit e_err, input logic [7:0] e_mask, input int e_cyc);
        int done_cyc;
        int busy_cyc;
        int done_cnt;
        bit fin;
        @(negedge clk);
        start = 1'b1;
        win   = w[3:0];
        data  = ref_v;
        ack   = ackst;
        @(posedge clk);
        done_cyc = -1;
        busy_cyc = 0;
        done_cnt = 0;
        fin      = 1'b0;
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk_res({tag, " start-clear"}, 1'b0, 8'h00, 0);
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                chk_res({tag, " at done"}, e_err, e_mask, e_cyc);
            end
            if (!busy && !done) fin = 1'b1;
            start = hold && busy && !done;
            ack   = ackw && busy && !done;
            win   = 4'($urandom);
            data  = (cyc <= w) ? dseq[cyc-1] : 8'($urandom);
        end
        chk({tag, " done cycle"}, done_cyc, w + 1);
        chk({tag, " busy cycles"}, busy_cyc, w + 1);
        chk({tag, " done count"}, done_cnt, 1);
        chk_res({tag, " held in idle"}, e_err, e_mask, e_cyc);
    endtask

    initial begin
        int         w;
        logic [7:0] r;
        logic [7:0] m;
        int         first;
        int         n_done;
        int         n_busy;

        rst_n = 1'b0;
        start = 1'b0;
        win   = '0;
        data  = '0;
        ack   = 1'b0;

        tbl[0] = '{5,  8'hA5, 16, 8'h00, 16, 8'h00, 0, 0, 0, 0, 8'h00, 0};
        tbl[1] = '{8,  8'h3C, 2,  8'h3D, 5,  8'hBD, 0, 0, 0, 1, 8'h81, 2};
        tbl[2] = '{0,  8'h5A, 16, 8'h00, 16, 8'h00, 0, 0, 1, 0, 8'h00, 0};
        tbl[3] = '{15, 8'h00, 14, 8'h40, 16, 8'h00, 0, 0, 0, 1, 8'h40, 14};
        tbl[4] = '{4,  8'hFF, 0,  8'hFE, 16, 8'h00, 1, 1, 0, 1, 8'h01, 0};
        tbl[5] = '{3,  8'h11, 1,  8'h13, 2,  8'h11, 0, 0, 0, 1, 8'h02, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk_res("reset", 1'b0, 8'h00, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 16; k++)
                dseq[k] = (k >= tbl[i].ib) ? tbl[i].vb : ((k >= tbl[i].ia) ? tbl[i].va : tbl[i].ref_v);
            run_window($sformatf("vec%0d", i), tbl[i].w, tbl[i].ref_v, tbl[i].hold, tbl[i].ackw,
                       tbl[i].ackst, tbl[i].e_err, tbl[i].e_mask, tbl[i].e_cyc);
        end

        // Results stay put in IDLE until ACK, then ACK clears them.
        repeat (3) @(negedge clk);
        chk_res("idle hold", 1'b1, 8'h02, 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk_res("ack clear", 1'b0, 8'h00, 0);

        for (int i = 0; i < 30; i++) begin
            w = $urandom_range(0, 15);
            r = 8'($urandom);
            for (int k = 0; k < 16; k++)
                dseq[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : r;
            m = 8'h00;
            first = -1;
            for (int k = 0; k < w; k++) begin
                m = m | (dseq[k] ^ r);
                if (first < 0 && dseq[k] != r) first = k;
            end
            run_window($sformatf("rnd%0d", i), w, r, 1'($urandom), 1'($urandom), 1'($urandom),
                       first >= 0, m, (first >= 0) ? first : 0);
        end

        // Asynchronous reset in the middle of a window with DATA toggling.
        @(negedge clk);
        start = 1'b1;
        win   = 4'd10;
        data  = 8'h55;
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            data  = ~data;
        end
        @(negedge clk);
        chk("pre-reset err", int'(err), 1);
        chk("pre-reset busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk_res("abort", 1'b0, 8'h00, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            data = ~data;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("post-reset done count", n_done, 0);
        chk("post-reset busy count", n_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
